// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//   Captures a fill-rectangle command from the decoder's op-code/operand
//   stream. It clips the rectangle to the display and emits one palette-index
//   pixel write per accepted cycle into the frame buffer write port.
//
// Ports
//   clock_in                     system clock
//   reset_in                     asynchronous active-high reset
//   op_code_in / op_code_valid_in  current command op code, valid for the whole command
//   operand_in / operand_valid_in  operand byte and its single-cycle strobe
//   operand_count_in             1-based index of the current operand
//   pixel_write_buffer_ready_in  frame buffer accepts a write this cycle
//   pixel_write_address_out      linear pixel address, y*SCREEN_WIDTH+x
//   pixel_write_data_out         palette index
//   pixel_write_enable_out       a write is presented and accepted this cycle
//   busy_out                     fill in progress; incoming commands are dropped
module rect_fill_engine #(
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 400,
  parameter logic [7:0]  OPCODE        = 8'h12
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [7:0]  op_code_in,
  input  logic        op_code_valid_in,
  input  logic [7:0]  operand_in,
  input  logic        operand_valid_in,
  input  logic [31:0] operand_count_in,
  input  logic        pixel_write_buffer_ready_in,
  output logic [17:0] pixel_write_address_out,
  output logic [3:0]  pixel_write_data_out,
  output logic        pixel_write_enable_out,
  output logic        busy_out
);

  localparam logic [10:0] WIDTH_11  = 11'(SCREEN_WIDTH);
  localparam logic [10:0] HEIGHT_11 = 11'(SCREEN_HEIGHT);
  localparam logic [17:0] STRIDE    = 18'(SCREEN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Captured command fields.
  logic [9:0]  x_reg;
  logic [8:0]  y_reg;
  logic [9:0]  w_reg;
  logic [8:0]  h_reg;
  logic [3:0]  color_reg;

  // Scan state.
  logic [10:0] x_end_reg;
  logic [10:0] y_end_reg;
  logic [10:0] cx_reg;
  logic [10:0] cy_reg;
  logic [17:0] address_reg;
  logic [17:0] row_base_reg;

  logic        accept;
  logic        launch;
  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [10:0] x_end_calc;
  logic [10:0] y_end_calc;
  logic        empty_rect;
  logic [17:0] y_times_w;
  logic [17:0] row_start;
  logic        last_col;
  logic        last_row;
  logic        write_now;

  // Operands are only taken while idle, so a command that arrives during a
  // fill cannot disturb the fields the running fill still reads.
  assign accept = op_code_valid_in && (op_code_in == OPCODE) &&
                  operand_valid_in && (state_reg == IDLE);
  assign launch = accept && (operand_count_in == 32'd9);

  // 11-bit sums: 10-bit x plus 10-bit w cannot overflow before clipping.
  assign x_sum      = {1'b0, x_reg} + {1'b0, w_reg};
  assign y_sum      = {2'b00, y_reg} + {2'b00, h_reg};
  assign x_end_calc = (x_sum > WIDTH_11)  ? WIDTH_11  : x_sum;
  assign y_end_calc = (y_sum > HEIGHT_11) ? HEIGHT_11 : y_sum;
  assign empty_rect = (w_reg == 10'd0) || (h_reg == 9'd0) ||
                      ({1'b0, x_reg} >= WIDTH_11) || ({2'b00, y_reg} >= HEIGHT_11);

  // Row start address, only used in SETUP. For the 640-wide display this is
  // 512*y + 128*y; the result wraps only for off-screen y, which never draws.
  generate
    if (SCREEN_WIDTH == 640) begin : g_row_640
      assign y_times_w = {y_reg, 9'b0} + {2'b00, y_reg, 7'b0};
    end else begin : g_row_generic
      assign y_times_w = 18'(y_reg) * STRIDE;
    end
  endgenerate
  assign row_start = y_times_w + 18'(x_reg);

  assign last_col  = (cx_reg == x_end_reg - 11'd1);
  assign last_row  = (cy_reg == y_end_reg - 11'd1);
  assign write_now = (state_reg == DRAW) && pixel_write_buffer_ready_in;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = SETUP;
      SETUP:   state_next = empty_rect ? IDLE : DRAW;
      DRAW:    if (write_now && last_col && last_row) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      x_end_reg    <= '0;
      y_end_reg    <= '0;
      cx_reg       <= '0;
      cy_reg       <= '0;
      address_reg  <= '0;
      row_base_reg <= '0;
    end else begin
      if (accept) begin
        case (operand_count_in)
          32'd1:   x_reg[9:8] <= operand_in[1:0];
          32'd2:   x_reg[7:0] <= operand_in;
          32'd3:   y_reg[8]   <= operand_in[0];
          32'd4:   y_reg[7:0] <= operand_in;
          32'd5:   w_reg[9:8] <= operand_in[1:0];
          32'd6:   w_reg[7:0] <= operand_in;
          32'd7:   h_reg[8]   <= operand_in[0];
          32'd8:   h_reg[7:0] <= operand_in;
          32'd9:   color_reg  <= operand_in[3:0];
          default: ;
        endcase
      end

      if (state_reg == SETUP) begin
        x_end_reg    <= x_end_calc;
        y_end_reg    <= y_end_calc;
        cx_reg       <= {1'b0, x_reg};
        cy_reg       <= {2'b00, y_reg};
        address_reg  <= row_start;
        row_base_reg <= row_start;
      end else if (write_now) begin
        if (last_col) begin
          // The row wrap happens in the same cycle as the last write of the
          // row, so the next row starts without a bubble. After the final
          // pixel the address is left where it is.
          if (!last_row) begin
            cx_reg       <= {1'b0, x_reg};
            cy_reg       <= cy_reg + 11'd1;
            row_base_reg <= row_base_reg + STRIDE;
            address_reg  <= row_base_reg + STRIDE;
          end
        end else begin
          cx_reg      <= cx_reg + 11'd1;
          address_reg <= address_reg + 18'd1;
        end
      end
    end
  end

  assign pixel_write_address_out = address_reg;
  assign pixel_write_data_out    = color_reg;
  assign pixel_write_enable_out  = write_now;
  assign busy_out                = (state_reg != IDLE);

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic [7:0]  op_code_in;
  logic        op_code_valid_in;
  logic [7:0]  operand_in;
  logic        operand_valid_in;
  logic [31:0] operand_count_in;
  logic        pixel_write_buffer_ready_in;
  logic [17:0] pixel_write_address_out;
  logic [3:0]  pixel_write_data_out;
  logic        pixel_write_enable_out;
  logic        busy_out;

  rect_fill_engine dut (
    .clock_in                    (clock_in),
    .reset_in                    (reset_in),
    .op_code_in                  (op_code_in),
    .op_code_valid_in            (op_code_valid_in),
    .operand_in                  (operand_in),
    .operand_valid_in            (operand_valid_in),
    .operand_count_in            (operand_count_in),
    .pixel_write_buffer_ready_in (pixel_write_buffer_ready_in),
    .pixel_write_address_out     (pixel_write_address_out),
    .pixel_write_data_out        (pixel_write_data_out),
    .pixel_write_enable_out      (pixel_write_enable_out),
    .busy_out                    (busy_out)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  // Write monitor: every accepted write and every busy cycle, sampled mid-cycle.
  int got_addr[$];
  int got_data[$];
  int got_cyc[$];
  int busy_cnt = 0;
  always @(negedge clock_in) begin
    if (pixel_write_enable_out) begin
      got_addr.push_back(int'(pixel_write_address_out));
      got_data.push_back(int'(pixel_write_data_out));
      got_cyc.push_back(cyc);
    end
    if (busy_out) busy_cnt = busy_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  bit rdy_random = 1'b0;
  int exp_addr[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
    if (rdy_random) pixel_write_buffer_ready_in = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: every on-screen pixel of the rectangle, row-major.
  task automatic model(input int x, input int y, input int w, input int h);
    int xe, ye;
    exp_addr.delete();
    xe = (x + w > 640) ? 640 : x + w;
    ye = (y + h > 400) ? 400 : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        exp_addr.push_back(yy * 640 + xx);
  endtask

  task automatic send_cmd(input int opc, input int x, input int y, input int w,
                          input int h, input int c, input int n, input bit gaps,
                          output int t9);
    int ops[10];
    t9 = -1;
    // Unused high bits carry junk; only the documented fields may be taken.
    ops[1] = ((x >> 8) & 3) | ($urandom_range(0, 63) << 2);
    ops[2] = x & 255;
    ops[3] = ((y >> 8) & 1) | ($urandom_range(0, 127) << 1);
    ops[4] = y & 255;
    ops[5] = ((w >> 8) & 3) | ($urandom_range(0, 63) << 2);
    ops[6] = w & 255;
    ops[7] = ((h >> 8) & 1) | ($urandom_range(0, 127) << 1);
    ops[8] = h & 255;
    ops[9] = (c & 15) | ($urandom_range(0, 15) << 4);
    op_code_in       = 8'(opc);
    op_code_valid_in = 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        operand_valid_in = 1'b0;
        tick();
      end
      operand_in       = 8'(ops[k]);
      operand_count_in = 32'(k);
      operand_valid_in = 1'b1;
      if (k == 9) t9 = cyc;
      tick();
    end
    operand_valid_in = 1'b0;
    op_code_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy_out && n < bound) begin
      tick();
      n++;
    end
    check("idle_timeout", int'(busy_out), 0);
    tick();
    tick();
  endtask

  task automatic run_fill(input string tag, input int x, input int y, input int w,
                          input int h, input int c, input bit rnd, output int b0);
    int bb, t9, n, bad;
    b0 = got_addr.size();
    bb = busy_cnt;
    rdy_random = rnd;
    if (!rnd) pixel_write_buffer_ready_in = 1'b1;
    model(x, y, w, h);
    send_cmd(8'h12, x, y, w, h, c, 9, rnd, t9);
    wait_idle(30000);
    n = got_addr.size() - b0;
    bad = 0;
    for (int i = 0; i < n && i < exp_addr.size(); i++)
      if (got_addr[b0 + i] != exp_addr[i] || got_data[b0 + i] != c) bad++;
    $display("fill %s x=%0d y=%0d w=%0d h=%0d c=%0d ready_rand=%0d writes=%0d",
             tag, x, y, w, h, c, rnd, n);
    check({tag, "_writes"}, n, exp_addr.size());
    check({tag, "_pixel_mismatches"}, bad, 0);
    if (!rnd) begin
      check({tag, "_busy_cycles"}, busy_cnt - bb, 1 + exp_addr.size());
      if (exp_addr.size() > 0 && n > 0) begin
        check({tag, "_first_latency"}, got_cyc[b0] - t9, 2);
        check({tag, "_burst_span"}, got_cyc[b0 + n - 1] - got_cyc[b0], n - 1);
      end
    end
    rdy_random = 1'b0;
    pixel_write_buffer_ready_in = 1'b1;
  endtask

  initial begin
    int b0, bb, t9, n, cnt2, nrst;
    reset_in = 1'b1;
    op_code_in = 8'h00;
    op_code_valid_in = 1'b0;
    operand_in = 8'h00;
    operand_valid_in = 1'b0;
    operand_count_in = 32'd0;
    pixel_write_buffer_ready_in = 1'b1;
    repeat (3) tick();
    check("rst_addr", int'(pixel_write_address_out), 0);
    check("rst_data", int'(pixel_write_data_out), 0);
    check("rst_en", int'(pixel_write_enable_out), 0);
    check("rst_busy", int'(busy_out), 0);
    reset_in = 1'b0;
    repeat (2) tick();

    // Basic fill.
    run_fill("basic", 10, 5, 2, 2, 7, 1'b0, b0);
    if (got_addr.size() >= b0 + 4) begin
      check("basic_a0", got_addr[b0], 3210);
      check("basic_a1", got_addr[b0 + 1], 3211);
      check("basic_a2", got_addr[b0 + 2], 3850);
      check("basic_a3", got_addr[b0 + 3], 3851);
    end
    check("basic_busy_after", int'(busy_out), 0);

    // Clipping at the bottom-right corner, and fully off-screen.
    run_fill("clip", 638, 399, 5, 5, 3, 1'b0, b0);
    if (got_addr.size() >= b0 + 2) begin
      check("clip_a0", got_addr[b0], 255998);
      check("clip_a1", got_addr[b0 + 1], 255999);
    end
    run_fill("offscreen", 700, 10, 5, 5, 4, 1'b0, b0);
    run_fill("zero_w", 5, 5, 0, 5, 4, 1'b0, b0);

    // Back-pressure: three stalled cycles after the first write.
    b0 = got_addr.size();
    pixel_write_buffer_ready_in = 1'b1;
    send_cmd(8'h12, 0, 0, 3, 1, 1, 9, 1'b0, t9);
    tick();
    for (int s = 0; s < 3; s++) begin
      tick();
      pixel_write_buffer_ready_in = 1'b0;
      @(negedge clock_in);
      #1;
      check("bp_stall_en", int'(pixel_write_enable_out), 0);
      check("bp_stall_addr", int'(pixel_write_address_out), 1);
    end
    tick();
    pixel_write_buffer_ready_in = 1'b1;
    wait_idle(100);
    n = got_addr.size() - b0;
    $display("fill backpressure x=0 y=0 w=3 h=1 c=1 writes=%0d", n);
    check("bp_writes", n, 3);
    if (n >= 3) begin
      check("bp_a0", got_addr[b0], 0);
      check("bp_a1", got_addr[b0 + 1], 1);
      check("bp_a2", got_addr[b0 + 2], 2);
      check("bp_data", got_data[b0 + 2], 1);
    end

    // Busy rejection: a second command mid-fill must vanish entirely.
    b0 = got_addr.size();
    model(20, 30, 100, 100);
    send_cmd(8'h12, 20, 30, 100, 100, 9, 9, 1'b0, t9);
    repeat (50) tick();
    send_cmd(8'h12, 0, 0, 5, 5, 2, 9, 1'b0, t9);
    wait_idle(30000);
    repeat (30) tick();
    n = got_addr.size() - b0;
    cnt2 = 0;
    for (int i = 0; i < n; i++) if (got_data[b0 + i] == 2) cnt2++;
    $display("fill busy_reject first=100x100 second_dropped writes=%0d", n);
    check("busy_rej_writes", n, 10000);
    check("busy_rej_color2", cnt2, 0);

    // Reset in the middle of a fill.
    b0 = got_addr.size();
    model(100, 100, 50, 50);
    send_cmd(8'h12, 100, 100, 50, 50, 6, 9, 1'b0, t9);
    n = 0;
    while (got_addr.size() - b0 < 20 && n < 200) begin
      tick();
      n++;
    end
    #2;
    reset_in = 1'b1;
    #1;
    check("midrst_addr", int'(pixel_write_address_out), 0);
    check("midrst_data", int'(pixel_write_data_out), 0);
    check("midrst_en", int'(pixel_write_enable_out), 0);
    check("midrst_busy", int'(busy_out), 0);
    nrst = got_addr.size();
    repeat (2) tick();
    reset_in = 1'b0;
    repeat (20) tick();
    $display("fill reset_mid x=100 y=100 w=50 h=50 writes=%0d", got_addr.size() - b0);
    check("midrst_writes", got_addr.size() - b0, 20);
    check("midrst_no_more", got_addr.size(), nrst);
    run_fill("post_reset", 1, 1, 1, 1, 5, 1'b0, b0);
    if (got_addr.size() > b0) check("post_reset_a0", got_addr[b0], 641);

    // Truncated command and a foreign op code: nothing may happen.
    b0 = got_addr.size();
    bb = busy_cnt;
    send_cmd(8'h12, 300, 200, 4, 4, 6, 6, 1'b0, t9);
    repeat (20) tick();
    send_cmd(8'h13, 300, 200, 4, 4, 6, 9, 1'b0, t9);
    repeat (20) tick();
    $display("cmd truncated+foreign_opcode writes=%0d busy=%0d", got_addr.size() - b0, busy_cnt - bb);
    check("trunc_writes", got_addr.size() - b0, 0);
    check("trunc_busy", busy_cnt - bb, 0);

    // Randomized fills, some with random back-pressure.
    for (int r = 0; r < 20; r++) begin
      int rx, ry, rw, rh, rc;
      rx = $urandom_range(0, 700);
      ry = $urandom_range(0, 450);
      rw = $urandom_range(0, 24);
      rh = $urandom_range(0, 12);
      rc = $urandom_range(0, 15);
      if (r % 5 == 0) begin
        rx = $urandom_range(600, 639);
        ry = $urandom_range(380, 399);
      end
      run_fill($sformatf("rand%0d", r), rx, ry, rw, rh, rc, 1'($urandom_range(0, 1)), b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
# rect_fill_engine

Command-driven rectangle fill stage sitting between the SPI command decoder and the frame buffers' pixel write port. Captures a fill-rectangle command (op code 0x12) from the decoder's op-code/operand stream, clips it to the 640×400 display, and emits one indexed-color pixel write per cycle into the current write buffer. Its outputs drive the frame buffers' pixel write address and data inputs, with back-pressure from the write-buffer-ready output.

## Interface
Parameters:
- SCREEN_WIDTH, 640, display width in pixels
- SCREEN_HEIGHT, 400, display height in pixels
- OPCODE, 8'h12, op code that triggers a fill

Ports:
- clock_in  input  1  system clock; single clock domain
- reset_in  input  1  asynchronous, active-high reset
- op_code_in  input  8  current command op code
- op_code_valid_in  input  1  high for the whole duration of a command
- operand_in  input  8  operand byte
- operand_valid_in  input  1  single-cycle strobe; operand_in is valid
- operand_count_in  input  32 (integer)  1-based index of the current operand
- pixel_write_buffer_ready_in  input  1  frame buffer accepts a write this cycle
- pixel_write_address_out  output  18  linear address, y*640+x
- pixel_write_data_out  output  4  palette index
- pixel_write_enable_out  output  1  write valid this cycle
- busy_out  output  1  a fill is in progress; new commands ignored

## Operation
- Operand map, accepted only when op_code_valid_in && op_code_in==OPCODE && operand_valid_in && !busy_out:
  - count 1: x[9:8] = operand[1:0]; count 2: x[7:0]
  - count 3: y[8] = operand[0]; count 4: y[7:0]
  - count 5: w[9:8]; count 6: w[7:0]; count 7: h[8]; count 8: h[7:0]
  - count 9: color = operand[3:0]; launches the fill
- Operands beyond 9 are ignored. A sequence that ends before count 9 never launches; its partial registers are overwritten by the next command.
- States:
  - IDLE: capture operands; go to SETUP on count 9.
  - SETUP: one cycle. Compute x_end = min(x+w, 640) and y_end = min(y+h, 400) using 11-bit arithmetic with no overflow. Load address = y*640+x and row_base = same. If w==0, h==0, x>=640 or y>=400, go to IDLE with no writes; otherwise go to DRAW.
  - DRAW: row-major scan. A write occurs on each cycle where pixel_write_buffer_ready_in is high.
    - After each write: cx++ and address++.
    - At cx==x_end-1: cy++, row_base += 640, address = row_base+640, cx = x.
    - After the write at (x_end-1, y_end-1), go to IDLE.
- Address is computed incrementally; no multiplier is permitted outside SETUP (y*640 is implemented as (y<<9)+(y<<7)).
- pixel_write_enable_out = (state==DRAW) && pixel_write_buffer_ready_in. Address and data remain stable while ready is low.
- busy_out is high in SETUP and DRAW.
- Reset mid-fill: immediate return to IDLE, all outputs 0, and captured operands cleared. No further writes occur.

## Timing
- Reset values: pixel_write_address_out=0, pixel_write_data_out=0, pixel_write_enable_out=0, busy_out=0.
- Count-9 operand sampled at edge N: SETUP during cycle N+1, with busy_out high from N+1. First write in cycle N+2 if ready is high.
- With ready held high, a clipped rectangle of W'×H' takes exactly W'*H' write cycles, back to back, with no bubbles at row boundaries.
- busy_out falls on the cycle after the last write. A count-9 operand arriving in that cycle is accepted.
- Degenerate (empty) fill: busy_out is high for exactly 1 cycle (SETUP) with zero writes.
- Commands arriving while busy_out is high are dropped entirely, including their operand capture.

## Test plan
- Basic fill: x=10, y=5, w=2, h=2, color=7 with ready high. Required: 4 consecutive writes to addresses 3210, 3211, 3850, 3851 with data 7; first write 2 cycles after count 9; busy_out then low.
- Clipping: x=638, y=399, w=5, h=5, color=3. Required: exactly 2 writes, to 255998 and 255999. A second case with x=700 gives zero writes and busy_out high for 1 cycle.
- Back-pressure: 3×1 fill at (0,0), color=1, with ready low for 3 cycles after the first write. Required: enable low during the stall, address held at 1, then 1 and 2 written; total 3 writes.
- Busy rejection: start a 100×100 fill, then send a second 0x12 command at (0,0) color 2 mid-fill. Required: only the 10000 writes of the first fill occur; no data value 2 is ever written.
- Reset mid-fill: assert reset_in during a 50×50 fill at write 20. Required: all outputs 0 asynchronously, no writes afterwards. A following 1×1 fill at (1,1) color 5 writes address 641 only.
- Truncated command: op_code_valid_in drops after count 6. Required: no writes and busy_out stays 0.
